// File: rtl/gate_sweep_pkg.sv
// -----------------------------------------------------------------------------
// gate_sweep_pkg
//
// Shared definitions for the exhaustive gate sweep checker:
//   - gate mode codes seen on the 3-bit mode input (6 and 7 are reserved and
//     are checked as AND)
//   - the sweep controller state encoding
//   - a helper that folds the reserved mode codes onto AND
// -----------------------------------------------------------------------------
package gate_sweep_pkg;

    localparam logic [2:0] MODE_AND  = 3'd0;
    localparam logic [2:0] MODE_OR   = 3'd1;
    localparam logic [2:0] MODE_XOR  = 3'd2;
    localparam logic [2:0] MODE_NAND = 3'd3;
    localparam logic [2:0] MODE_NOR  = 3'd4;
    localparam logic [2:0] MODE_XNOR = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Reserved codes behave exactly like AND, so fold them once here and let
    // every consumer decode only the six real gates.
    function automatic logic [2:0] canon_mode(input logic [2:0] mode);
        return (mode > MODE_XNOR) ? MODE_AND : mode;
    endfunction

endpackage

// File: rtl/gate_ref_model.sv
// -----------------------------------------------------------------------------
// gate_ref_model
//
// Combinational reference for an N_IN-input logic gate. Given an input vector
// and a gate mode it returns the value a correct gate must produce.
//
// Parameters:
//   N_IN  number of gate inputs (1..16)
//
// Ports:
//   vec   input  [N_IN-1:0]  gate input vector
//   mode  input  [2:0]       gate selection (see gate_sweep_pkg; 6/7 = AND)
//   y     output             expected gate output
//
// For N_IN = 1 the reductions collapse to vec[0], so AND, OR and XOR all
// return the single input without any special casing.
// -----------------------------------------------------------------------------
module gate_ref_model #(
    parameter int N_IN = 2
) (
    input  logic [N_IN-1:0] vec,
    input  logic [2:0]      mode,
    output logic            y
);
    import gate_sweep_pkg::*;

    logic all_ones;
    logic any_one;
    logic odd_parity;

    assign all_ones   = &vec;
    assign any_one    = |vec;
    assign odd_parity = ^vec;

    always_comb begin
        // NOTE: y gets a value on every path (default arm covers AND and the
        // reserved codes), so no latch can be inferred here.
        case (canon_mode(mode))
            MODE_OR:   y = any_one;
            MODE_XOR:  y = odd_parity;
            MODE_NAND: y = ~all_ones;
            MODE_NOR:  y = ~any_one;
            MODE_XNOR: y = ~odd_parity;
            default:   y = all_ones;
        endcase
    end

endmodule

// File: rtl/gate_sweep_checker.sv
// -----------------------------------------------------------------------------
// gate_sweep_checker
//
// Self-checking exhaustive stimulus generator for an N_IN-input combinational
// gate. On start it drives every input vector 0 .. 2^N_IN-1 in order, holds
// each for SETTLE+1 cycles, samples the gate output in the last of those
// cycles and compares it with gate_ref_model. Mismatches are counted
// (saturating) and the first failing vector is captured.
//
// Parameters:
//   N_IN    number of gate inputs (1..16)
//   SETTLE  extra hold cycles per vector before sampling (0..255)
//   ERR_W   width of the mismatch counter
//
// Ports:
//   clk              clock, rising edge
//   rst              synchronous active-high reset
//   start            sweep request, honoured only when idle
//   mode   [2:0]     gate to check (0 AND,1 OR,2 XOR,3 NAND,4 NOR,5 XNOR,
//                    6/7 AND), latched on start
//   stim   [N_IN-1:0] registered vector driven to the gate under test
//   dut_y            gate-under-test output
//   busy             sweep in progress
//   done             one-cycle pulse after the last compare
//   pass             last completed sweep had zero mismatches
//   err_count [ERR_W-1:0] mismatches in the current / last sweep
//   first_err_valid  at least one mismatch recorded
//   first_err_vec [N_IN-1:0] stim value of the first mismatch
//
// Build option:
//   GATE_SWEEP_STOP_ON_ERR_EN  when defined, the first mismatch ends the
//                              sweep immediately (err_count = 1, pass = 0).
//                              When undefined every vector is always driven.
// -----------------------------------------------------------------------------
module gate_sweep_checker #(
    parameter int N_IN   = 2,
    parameter int SETTLE = 1,
    parameter int ERR_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       mode,
    output logic [N_IN-1:0]  stim,
    input  logic             dut_y,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic             first_err_valid,
    output logic [N_IN-1:0]  first_err_vec
);
    import gate_sweep_pkg::*;

`ifdef GATE_SWEEP_STOP_ON_ERR_EN
    localparam bit STOP_ON_ERR = 1'b1;
`else
    localparam bit STOP_ON_ERR = 1'b0;
`endif

    // With no settle time a new vector is sampled in the very cycle it
    // appears, so the controller skips HOLD entirely.
    localparam state_t VEC_STATE = (SETTLE == 0) ? ST_SAMPLE : ST_HOLD;

    // HOLD occupies SETTLE cycles; the counter starts at 0 for each vector
    // and leaves HOLD on its last value. Unused when SETTLE == 0.
    localparam logic [7:0] HOLD_LAST = 8'(SETTLE - 1);

    localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

    state_t           state, state_nxt;
    logic [7:0]       hold_cnt, hold_cnt_nxt;
    logic [2:0]       mode_q, mode_nxt;
    logic [N_IN-1:0]  stim_nxt;
    logic [ERR_W-1:0] err_nxt;
    logic             pass_nxt;
    logic             fev_valid_nxt;
    logic [N_IN-1:0]  fev_nxt;

    logic             ref_y;
    logic             mismatch;
    logic             last_vec;

    // Expected value for the vector currently on stim, using the gate mode
    // captured at start so a changing mode input cannot corrupt a sweep.
    gate_ref_model #(
        .N_IN (N_IN)
    ) u_ref (
        .vec  (stim),
        .mode (mode_q),
        .y    (ref_y)
    );

    assign mismatch = (dut_y != ref_y);
    assign last_vec = &stim;

    // Status flags decode straight from the registered state, so they are
    // glitch-free and take their reset values with the state register.
    assign busy = (state == ST_HOLD) || (state == ST_SAMPLE);
    assign done = (state == ST_DONE);

    always_comb begin
        state_nxt     = state;
        hold_cnt_nxt  = hold_cnt;
        mode_nxt      = mode_q;
        stim_nxt      = stim;
        err_nxt       = err_count;
        pass_nxt      = pass;
        fev_valid_nxt = first_err_valid;
        fev_nxt       = first_err_vec;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    mode_nxt      = mode;
                    stim_nxt      = '0;
                    hold_cnt_nxt  = '0;
                    err_nxt       = '0;
                    pass_nxt      = 1'b0;
                    fev_valid_nxt = 1'b0;
                    fev_nxt       = '0;
                    state_nxt     = VEC_STATE;
                end
            end

            ST_HOLD: begin
                if (hold_cnt == HOLD_LAST) begin
                    state_nxt = ST_SAMPLE;
                end else begin
                    hold_cnt_nxt = hold_cnt + 8'd1;
                end
            end

            ST_SAMPLE: begin
                if (mismatch) begin
                    if (err_count != ERR_MAX) begin
                        err_nxt = err_count + 1'b1;
                    end
                    if (!first_err_valid) begin
                        fev_valid_nxt = 1'b1;
                        fev_nxt       = stim;
                    end
                end

                if (last_vec || (STOP_ON_ERR && mismatch)) begin
                    // The verdict includes this final compare. The counter
                    // saturates instead of wrapping, so "no mismatch so far
                    // and none now" is exactly err_nxt == 0.
                    pass_nxt  = (err_count == '0) && !mismatch;
                    state_nxt = ST_DONE;
                end else begin
                    stim_nxt     = stim + 1'b1;
                    hold_cnt_nxt = '0;
                    state_nxt    = VEC_STATE;
                end
            end

            ST_DONE: begin
                // start is deliberately ignored here; IDLE accepts it next.
                state_nxt = ST_IDLE;
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // NOTE: the reset branch sits inside the clocked block, making it
    // synchronous; a mid-sweep reset discards the partial result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= ST_IDLE;
            hold_cnt        <= '0;
            mode_q          <= MODE_AND;
            stim            <= '0;
            err_count       <= '0;
            pass            <= 1'b0;
            first_err_valid <= 1'b0;
            first_err_vec   <= '0;
        end else begin
            // NOTE: non-blocking updates so every register samples the
            // pre-edge values computed by the next-state logic.
            state           <= state_nxt;
            hold_cnt        <= hold_cnt_nxt;
            mode_q          <= mode_nxt;
            stim            <= stim_nxt;
            err_count       <= err_nxt;
            pass            <= pass_nxt;
            first_err_valid <= fev_valid_nxt;
            first_err_vec   <= fev_nxt;
        end
    end

endmodule
